// File: rtl/nvdla_dbb_arbiter.sv
// Round-robin arbiter funnelling NB_REQ DBB requesters into one downstream bridge port.
// Optional watchdog with sticky timeout_o is enabled by defining NVDLA_DBB_ARB_TIMEOUT_EN.
module nvdla_dbb_arbiter #(
   parameter int NB_REQ         = 2,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic [NB_REQ-1:0]        req_valid_i,
   output logic [NB_REQ-1:0]        req_ready_o,
   input  logic [NB_REQ-1:0]        req_write_i,
   input  logic [NB_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NB_REQ*8-1:0]      req_len_i,
   input  logic [NB_REQ*8-1:0]      req_id_i,
   output logic                     dbb_valid_o,
   input  logic                     dbb_ready_i,
   output logic                     dbb_write_o,
   output logic [ADDR_W-1:0]        dbb_addr_o,
   output logic [7:0]               dbb_len_o,
   output logic [7:0]               dbb_id_o,
   input  logic                     dbb_done_i,
   output logic [NB_REQ-1:0]        grant_o,
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
   output logic                     timeout_o,
`endif
   output logic                     busy_o
);

   localparam int IDX_W = $clog2(NB_REQ);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    r_owner;
   logic [NB_REQ-1:0]   r_grant;
   logic                r_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_len;
   logic [7:0]          r_id;

   logic                w_found;
   logic [IDX_W-1:0]    w_winIdx;
   logic [IDX_W-1:0]    w_cand;
   int                  w_sum;
   logic                w_accept;
   logic                w_expired;
   logic [ADDR_W-1:0]   w_addrArr [NB_REQ];
   logic [7:0]          w_lenArr  [NB_REQ];
   logic [7:0]          w_idArr   [NB_REQ];

   for (genvar k = 0; k < NB_REQ; k++) begin : g_unpack
      assign w_addrArr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
      assign w_lenArr[k]  = req_len_i[k*8 +: 8];
      assign w_idArr[k]   = req_id_i[k*8 +: 8];
   end

   function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(NB_REQ - 1)) ? '0 : idx + IDX_W'(1);
   endfunction

   // Search for the first valid requester starting at r_ptr, wrapping at NB_REQ.
   always_comb begin
      w_found  = 1'b0;
      w_winIdx = '0;
      w_sum    = 0;
      w_cand   = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         w_sum = int'(r_ptr) + i;
         if (w_sum >= NB_REQ) w_sum = w_sum - NB_REQ;
         w_cand = IDX_W'(w_sum);
         if (!w_found && req_valid_i[w_cand]) begin
            w_found  = 1'b1;
            w_winIdx = w_cand;
         end
      end
   end

   assign w_accept    = rst_ni && !clear_i && (r_state == IDLE) && w_found;
   assign req_ready_o = w_accept ? (NB_REQ'(1) << w_winIdx) : '0;

   assign dbb_valid_o = (r_state == ISSUE);
   assign dbb_write_o = dbb_valid_o & r_write;
   assign dbb_addr_o  = dbb_valid_o ? r_addr : '0;
   assign dbb_len_o   = dbb_valid_o ? r_len  : '0;
   assign dbb_id_o    = dbb_valid_o ? r_id   : '0;
   assign grant_o     = r_grant;
   assign busy_o      = (r_state != IDLE);

`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
   logic [15:0] r_wdCnt;
   logic        r_timeout;
   assign timeout_o = r_timeout;
   assign w_expired = (r_wdCnt >= 16'(TIMEOUT_CYCLES - 1));
`else
   assign w_expired = 1'b0;
`endif

   // Done outranks the watchdog, which outranks the downstream handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_grant <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_id    <= '0;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
         r_wdCnt   <= '0;
         r_timeout <= 1'b0;
`endif
      end else if (clear_i) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_grant <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_id    <= '0;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
         r_wdCnt   <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_write <= req_write_i[w_winIdx];
                  r_addr  <= w_addrArr[w_winIdx];
                  r_len   <= w_lenArr[w_winIdx];
                  r_id    <= w_idArr[w_winIdx];
                  if (w_lenArr[w_winIdx] != 8'd0) begin
                     r_state <= ISSUE;
                     r_owner <= w_winIdx;
                     r_grant <= NB_REQ'(1) << w_winIdx;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
                     r_wdCnt <= '0;
`endif
                  end else begin
                     r_ptr <= nextIdx(w_winIdx);
                  end
               end
            end
            ISSUE, WAIT_DONE: begin
               if (r_state == WAIT_DONE && dbb_done_i) begin
                  r_state <= IDLE;
                  r_ptr   <= nextIdx(r_owner);
                  r_grant <= '0;
               end else if (w_expired) begin
                  r_state <= IDLE;
                  r_ptr   <= nextIdx(r_owner);
                  r_grant <= '0;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
                  r_timeout <= 1'b1;
`endif
               end else if (r_state == ISSUE && dbb_ready_i) begin
                  r_state <= WAIT_DONE;
               end
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
               r_wdCnt <= r_wdCnt + 16'd1;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nvdla_dbb_arbiter.sv
// Self-checking bench for nvdla_dbb_arbiter: transaction-level model compared every cycle
// plus directed scenarios with literal expectations.
module tb_nvdla_dbb_arbiter;

   localparam int NB = 2;
   localparam int AW = 32;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
   localparam int TO   = 16;
   localparam bit TOEN = 1'b1;
`else
   localparam int TO   = 1024;
   localparam bit TOEN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clear = 1'b0;
   logic [NB-1:0]   reqValid = '0;
   logic [NB-1:0]   reqReady;
   logic [NB-1:0]   reqWrite = '0;
   logic [NB*AW-1:0] reqAddr = '0;
   logic [NB*8-1:0] reqLen = '0;
   logic [NB*8-1:0] reqId = '0;
   logic            dbbValid, dbbWrite;
   logic            dbbReady = 1'b0;
   logic            dbbDone = 1'b0;
   logic [AW-1:0]   dbbAddr;
   logic [7:0]      dbbLen, dbbId;
   logic [NB-1:0]   grant;
   logic            busy;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
   logic            timeout;
`endif

   nvdla_dbb_arbiter #(.NB_REQ(NB), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .req_valid_i(reqValid), .req_ready_o(reqReady), .req_write_i(reqWrite),
      .req_addr_i(reqAddr), .req_len_i(reqLen), .req_id_i(reqId),
      .dbb_valid_o(dbbValid), .dbb_ready_i(dbbReady), .dbb_write_o(dbbWrite),
      .dbb_addr_o(dbbAddr), .dbb_len_o(dbbLen), .dbb_id_o(dbbId),
      .dbb_done_i(dbbDone), .grant_o(grant),
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
      .timeout_o(timeout),
`endif
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Transaction model: owner index (-1 when idle), whether the request is still being offered,
   // the next round-robin start, the captured request and the cycles spent on the transaction.
   int          mOwner = -1;
   bit          mIssue = 1'b0;
   int          mPtr = 0;
   logic        mWrite = 1'b0;
   logic [31:0] mAddr = '0;
   logic [7:0]  mLen = '0, mId = '0;
   int          mBusy = 0;
   bit          mTimeout = 1'b0;
   int          mWin;

   function automatic int pickWinner(input logic [NB-1:0] v, input int ptr);
      for (int i = 0; i < NB; i++) if (v[(ptr + i) % NB]) return (ptr + i) % NB;
      return -1;
   endfunction

   always_comb mWin = pickWinner(reqValid, mPtr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clear) begin
         mOwner <= -1; mIssue <= 1'b0; mPtr <= 0; mWrite <= 1'b0;
         mAddr <= '0; mLen <= '0; mId <= '0; mBusy <= 0; mTimeout <= 1'b0;
      end else if (mOwner < 0) begin
         if (mWin >= 0) begin
            mWrite <= reqWrite[mWin];
            mAddr  <= reqAddr[mWin*AW +: AW];
            mLen   <= reqLen[mWin*8 +: 8];
            mId    <= reqId[mWin*8 +: 8];
            if (reqLen[mWin*8 +: 8] != 8'd0) begin
               mOwner <= mWin; mIssue <= 1'b1; mBusy <= 0;
            end else begin
               mPtr <= (mWin + 1) % NB;
            end
         end
      end else begin
         if (!mIssue && dbbDone) begin
            mOwner <= -1; mPtr <= (mOwner + 1) % NB;
         end else if (TOEN && mBusy + 1 >= TO) begin
            mOwner <= -1; mIssue <= 1'b0; mPtr <= (mOwner + 1) % NB; mTimeout <= 1'b1;
         end else if (mIssue && dbbReady) begin
            mIssue <= 1'b0;
         end
         mBusy <= mBusy + 1;
      end
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      checkOutput("ready", reqReady,
                  (rst_n && !clear && mOwner < 0 && mWin >= 0) ? (1 << mWin) : 0);
      checkOutput("grant", grant, (mOwner >= 0) ? (1 << mOwner) : 0);
      checkOutput("busy", busy, mOwner >= 0);
      checkOutput("dbbValid", dbbValid, mIssue);
      checkOutput("dbbFields", {dbbWrite, dbbAddr, dbbLen, dbbId},
                  mIssue ? {mWrite, mAddr, mLen, mId} : 49'd0);
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
      checkOutput("timeout", timeout, mTimeout);
`endif
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic applyStimulus(input int k, input logic wr, input logic [31:0] addr,
                                input logic [7:0] len, input logic [7:0] id);
      reqWrite[k]          = wr;
      reqAddr[k*AW +: AW]  = addr;
      reqLen[k*8 +: 8]     = len;
      reqId[k*8 +: 8]      = id;
      reqValid[k]          = 1'b1;
   endtask

   task automatic waitReady(input int k, output logic [NB-1:0] vec, output int waited);
      waited = 0;
      vec    = '0;
      while (1) begin
         @(negedge clk);
         if (reqReady[k]) begin
            vec = reqReady;
            break;
         end
         waited++;
         if (waited >= 50) begin
            checks++;
            $display("[TB] FAIL waitReady%0d: got no accept, expected one within 50 cycles", k);
            break;
         end
      end
      tick();
      reqValid[k] = 1'b0;
   endtask

   task automatic finishTxn(input int readyDelay, input int doneDelay);
      repeat (readyDelay) tick();
      dbbReady = 1'b1;
      tick();
      dbbReady = 1'b0;
      repeat (doneDelay) tick();
      dbbDone = 1'b1;
      tick();
      dbbDone = 1'b0;
   endtask

   logic [NB-1:0] vec;
   int            waited;
   int            busyCnt;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] aborted");
   end

   initial begin
      applyStimulus(0, 1'b0, 32'hA000, 8'd4, 8'h10);
      applyStimulus(1, 1'b1, 32'hB000, 8'd4, 8'h11);
      @(negedge clk);
      checkOutput("rst_ready", reqReady, 2'b00);
      checkOutput("rst_grant", grant, 2'b00);
      checkOutput("rst_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Both requesters valid out of reset: 0 first, then 1.
      waitReady(0, vec, waited);
      checkOutput("s1_first_ready", vec, 2'b01);
      checkOutput("s1_first_wait", waited, 0);
      @(negedge clk);
      checkOutput("s1_dbb_valid", dbbValid, 1'b1);
      checkOutput("s1_grant0", grant, 2'b01);
      checkOutput("s1_len", dbbLen, 8'd4);
      finishTxn(1, 2);
      waitReady(1, vec, waited);
      checkOutput("s1_second_ready", vec, 2'b10);
      @(negedge clk);
      checkOutput("s1_grant1", grant, 2'b10);
      finishTxn(1, 0);

      // rr_ptr back at 0, then a zero-length request moves it to 1 without going busy.
      applyStimulus(0, 1'b0, 32'hC000, 8'd0, 8'h20);
      applyStimulus(1, 1'b0, 32'hD000, 8'd3, 8'h21);
      waitReady(0, vec, waited);
      checkOutput("len0_ready", vec, 2'b01);
      applyStimulus(0, 1'b0, 32'hC100, 8'd2, 8'h22);
      @(negedge clk);
      checkOutput("len0_busy", busy, 1'b0);
      checkOutput("len0_dbb_valid", dbbValid, 1'b0);
      checkOutput("len0_next_ready", reqReady, 2'b10);
      tick();
      reqValid[1] = 1'b0;
      finishTxn(0, 0);
      waitReady(0, vec, waited);
      checkOutput("len0_then0_ready", vec, 2'b01);
      finishTxn(0, 1);

      // Delayed downstream ready: fields held, done ignored while issuing.
      applyStimulus(1, 1'b1, 32'h1000, 8'd8, 8'h5A);
      waitReady(1, vec, waited);
      checkOutput("s2_ready", vec, 2'b10);
      for (int i = 0; i < 3; i++) begin
         dbbDone = 1'b1;
         @(negedge clk);
         checkOutput("s2_hold_fields", {dbbValid, dbbWrite, dbbAddr, dbbLen, dbbId},
                     {1'b1, 1'b1, 32'h1000, 8'd8, 8'h5A});
         checkOutput("s2_hold_ready", reqReady, 2'b00);
         tick();
      end
      dbbDone  = 1'b0;
      dbbReady = 1'b1;
      @(negedge clk);
      checkOutput("s2_hs_addr", dbbAddr, 32'h1000);
      tick();
      dbbReady = 1'b0;
      @(negedge clk);
      checkOutput("s2_wait_fields", {dbbValid, dbbWrite, dbbAddr, dbbLen, dbbId}, 50'd0);
      checkOutput("s2_wait_busy", busy, 1'b1);
      tick();
      dbbDone = 1'b1;
      tick();
      dbbDone = 1'b0;

      // Clear in WAIT_DONE together with done: rr_ptr returns to 0, not owner+1.
      applyStimulus(0, 1'b0, 32'h2000, 8'd4, 8'h33);
      waitReady(0, vec, waited);
      dbbReady = 1'b1;
      tick();
      dbbReady = 1'b0;
      clear    = 1'b1;
      dbbDone  = 1'b1;
      tick();
      clear    = 1'b0;
      dbbDone  = 1'b0;
      @(negedge clk);
      checkOutput("clr_busy", busy, 1'b0);
      checkOutput("clr_grant", grant, 2'b00);
      tick();
      applyStimulus(0, 1'b0, 32'h3000, 8'd1, 8'h40);
      applyStimulus(1, 1'b1, 32'h3100, 8'd2, 8'h41);
      waitReady(0, vec, waited);
      checkOutput("clr_ptr_ready", vec, 2'b01);
      finishTxn(0, 0);
      waitReady(1, vec, waited);
      checkOutput("clr_next_ready", vec, 2'b10);
      finishTxn(0, 0);

      // Missing done: watchdog abort when enabled, indefinite wait otherwise.
      applyStimulus(0, 1'b0, 32'h4000, 8'd4, 8'h50);
      applyStimulus(1, 1'b0, 32'h4100, 8'd4, 8'h51);
      waitReady(0, vec, waited);
      dbbReady = 1'b1;
`ifdef NVDLA_DBB_ARB_TIMEOUT_EN
      busyCnt = 0;
      while (busyCnt < 100) begin
         @(negedge clk);
         if (!busy) break;
         busyCnt++;
      end
      checkOutput("to_busy_cycles", busyCnt, 16);
      checkOutput("to_flag", timeout, 1'b1);
      checkOutput("to_next_ready", reqReady, 2'b10);
      tick();
      dbbReady    = 1'b0;
      reqValid[1] = 1'b0;
      finishTxn(0, 0);
      @(negedge clk);
      checkOutput("to_sticky", timeout, 1'b1);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      @(negedge clk);
      checkOutput("to_cleared", timeout, 1'b0);
      tick();
`else
      busyCnt = 0;
      repeat (30) tick();
      @(negedge clk);
      checkOutput("hang_busy", busy, 1'b1);
      checkOutput("hang_grant", grant, 2'b01);
      tick();
      dbbReady = 1'b0;
      dbbDone  = 1'b1;
      tick();
      dbbDone  = 1'b0;
      waitReady(1, vec, waited);
      checkOutput("hang_next_ready", vec, 2'b10);
      finishTxn(0, 0);
`endif

      repeat (2) tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/nvdla_dbb_arbiter.md
NVDLA_DBB_ARBITER -- requirements
Module: nvdla_dbb_arbiter

Interface
REQ-001 Parameter NB_REQ, default 2: number of DBB requesters, range 2..8.
REQ-002 Parameter ADDR_W, default 32: request address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in cycles, range 1..65535.
REQ-004 Port clk_i, input, 1: clock.
REQ-005 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 Port clear_i, input, 1: synchronous clear.
REQ-007 Port req_valid_i, input, NB_REQ: per-requester request valid.
REQ-008 Port req_ready_o, output, NB_REQ: per-requester accept pulse.
REQ-009 Port req_write_i, input, NB_REQ: 1 = write, 0 = read.
REQ-010 Port req_addr_i, input, NB_REQ*ADDR_W: packed addresses; requester k is in slice k.
REQ-011 Port req_len_i, input, NB_REQ*8: packed burst lengths in DBB beats.
REQ-012 Port req_id_i, input, NB_REQ*8: packed transaction IDs.
REQ-013 Ports dbb_valid_o (output, 1) and dbb_ready_i (input, 1): downstream request handshake to the hwpe2dbb bridge.
REQ-014 Ports dbb_write_o (1), dbb_addr_o (ADDR_W), dbb_len_o (8) and dbb_id_o (8), all outputs: forwarded request fields.
REQ-015 Port dbb_done_i, input, 1: single-cycle pulse marking downstream transaction completion.
REQ-016 Port grant_o, output, NB_REQ: one-hot owner of the current transaction, 0 when idle.
REQ-017 Port busy_o, output, 1: high when the state is not IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT_DONE.
REQ-019 In IDLE with any req_valid_i set, the block SHALL select the winner by round-robin, starting the search at index rr_ptr.
REQ-020 In that same cycle it SHALL assert req_ready_o for the winner only, register that requester's write, addr, len and id fields, and register the one-hot grant.
REQ-021 In that cycle, if the winner's len is nonzero the FSM SHALL go to ISSUE; if len == 0 it SHALL stay in IDLE and set rr_ptr = winner+1 mod NB_REQ.
REQ-022 In ISSUE, dbb_valid_o SHALL be 1 and dbb_* outputs SHALL show the registered fields, held stable until dbb_ready_i.
REQ-023 The request-accept to dbb_valid_o latency SHALL be exactly 1 cycle.
REQ-024 In ISSUE with dbb_ready_i high, the FSM SHALL go to WAIT_DONE; dbb_valid_o SHALL drop in the next cycle.
REQ-025 In WAIT_DONE with dbb_done_i high, the FSM SHALL go to IDLE, set rr_ptr = winner+1 mod NB_REQ, and clear grant_o.
REQ-026 dbb_done_i SHALL be ignored in IDLE and ISSUE.
REQ-027 No new request SHALL be accepted before the state returns to IDLE; the earliest next accept is the cycle after done.
REQ-028 req_ready_o SHALL be 0 for every requester outside the accept cycle.
REQ-029 rr_ptr wrap: index NB_REQ-1 SHALL be followed by 0.
REQ-030 A single active requester SHALL be granted on every arbitration, whatever rr_ptr holds.
REQ-031 When not in ISSUE, dbb_* data outputs SHALL be 0.

Reset
REQ-032 On rst_ni low, the block SHALL asynchronously enter IDLE.
REQ-033 On rst_ni low, rr_ptr, grant_o, all registered fields, req_ready_o, dbb_valid_o and busy_o SHALL be 0.
REQ-034 clear_i high SHALL restore the same values on the next clock edge, from any state, including mid-transaction.
REQ-035 When clear_i is high, a pending dbb_done_i SHALL be discarded.

Configuration
REQ-036 With macro NVDLA_DBB_ARB_TIMEOUT_EN defined, the block SHALL add output timeout_o (1 bit, sticky) and a 16-bit watchdog counter.
REQ-037 With the macro defined, the counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE or WAIT_DONE.
REQ-038 With the macro defined, when the counter reaches TIMEOUT_CYCLES the block SHALL set timeout_o, go to IDLE and advance rr_ptr.
REQ-039 With the macro defined, timeout_o SHALL clear only on reset or clear_i.
REQ-040 Without the macro, neither the timeout_o port nor the counter SHALL exist, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-041 NB_REQ=2; requesters 0 and 1 valid together at reset, each len=4 -> grant 0 first, dbb_valid_o 1 cycle after accept; after done, grant 1; after its done, rr_ptr=0.
REQ-042 Requester 1 only, addr=0x1000, len=8, id=0x5A, write=1; dbb_ready_i delayed 3 cycles -> dbb_* fields stable throughout ISSUE, single req_ready_o pulse.
REQ-043 len=0 request from requester 0 -> req_ready_o pulse, no dbb_valid_o, rr_ptr=1, busy_o stays 0.
REQ-044 clear_i asserted in WAIT_DONE, with dbb_done_i high in the same cycle -> next cycle IDLE, grant_o=0, rr_ptr=0.
REQ-045 With NVDLA_DBB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, dbb_done_i never sent -> timeout_o=1 and IDLE after 16 cycles, and the next requester is granted.
